// File: rtl/cpu_ctrl_hs.sv
// cpu_ctrl_hs: multi-cycle IF/ID/EX/MEM sequencer with a stallable
// request/ready IO bus, bus timeout and precise exceptions.
module cpu_ctrl_hs #(
  parameter logic [31:0] RESET_PC    = 32'h8000_0000,
  parameter logic [31:0] EXC_VECTOR  = 32'h8000_1180,
  parameter int unsigned BUS_TIMEOUT = 255,
  parameter int unsigned TO_W        = 8
) (
  input  logic        clk,
  input  logic        rst,
  output logic        io_req,
  output logic [3:0]  io_mode,
  output logic [31:0] io_addr,
  output logic [31:0] io_wdata,
  input  logic        io_ready,
  input  logic [31:0] io_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] next_pc,
  input  logic        dec_rd_ready,
  input  logic [4:0]  dec_rd_idx,
  input  logic [31:0] dec_rd_data,
  input  logic        dec_is_jump,
  input  logic [31:0] dec_jump_pc,
  input  logic [3:0]  dec_io_mode,
  input  logic [31:0] alu_out,
  output logic [4:0]  reg_rd,
  output logic [31:0] reg_wdata,
  output logic        exc_valid,
  output logic [4:0]  exc_code,
  output logic [31:0] exc_epc,
  output logic        exc_bd,
  output logic [31:0] exc_badvaddr
);

  // IO operation codes shared with the IO/memory arbiter
  localparam logic [3:0] IO_NOP = 4'h0;
  localparam logic [3:0] IO_LW  = 4'h1;
  localparam logic [3:0] IO_SW  = 4'h2;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_BUS  = 5'd7;
  localparam logic [4:0] EXC_RI   = 5'd10;

  // Timeout fires on the last allowed wait cycle, so io_req stays high
  // for exactly BUS_TIMEOUT cycles before the exception.
  localparam bit          TO_EN     = (BUS_TIMEOUT != 0);
  localparam int unsigned TO_LAST_I = TO_EN ? BUS_TIMEOUT - 1 : 0;
  localparam logic [TO_W-1:0] TO_LAST = TO_LAST_I[TO_W-1:0];

  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_EXC} state_e;

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d, dpc_q, dpc_d, inst_q, inst_d;
  logic [31:0]       inst_pc_q, inst_pc_d, addr_q, addr_d;
  logic              ds_q, ds_d;
  logic [TO_W-1:0]   wait_q, wait_d;
  logic [4:0]        exc_code_q, exc_code_d;
  logic [31:0]       exc_epc_q, exc_epc_d, exc_bad_q, exc_bad_d;
  logic              exc_bd_q, exc_bd_d;
  logic              mis_s, req_s, timeout_s;
  logic [31:0]       epc_s;

  // Faulting PC: the branch PC when the fault sits in a delay slot
  function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic ds);
    return ds ? (pc - 32'd4) : pc;
  endfunction

  assign mis_s     = ((dec_io_mode == IO_LW) || (dec_io_mode == IO_SW)) && (addr_q[1:0] != 2'b00);
  assign req_s     = ((state_q == S_IF) && (pc_q[1:0] == 2'b00)) || ((state_q == S_MEM) && !mis_s);
  assign timeout_s = TO_EN && req_s && !io_ready && (wait_q == TO_LAST);
  assign epc_s     = epc_of((state_q == S_IF) ? pc_q : inst_pc_q, ds_q);
  assign wait_d    = (req_s && !io_ready) ? (wait_q + TO_W'(1)) : '0;

  assign inst         = inst_q;
  assign inst_pc      = inst_pc_q;
  assign next_pc      = inst_pc_q + 32'd4;
  assign exc_valid    = (state_q == S_EXC);
  assign exc_code     = exc_valid ? exc_code_q : 5'd0;
  assign exc_epc      = exc_valid ? exc_epc_q : 32'd0;
  assign exc_bd       = exc_valid ? exc_bd_q : 1'b0;
  assign exc_badvaddr = exc_valid ? exc_bad_q : 32'd0;

  // Bus request fields, forced idle while reset is asserted
  always_comb begin
    io_req   = 1'b0;
    io_mode  = IO_NOP;
    io_addr  = 32'd0;
    io_wdata = 32'd0;
    if (rst) begin
      io_req = 1'b0;
    end else begin
      case (state_q)
        S_IF: begin
          io_req  = req_s;
          io_mode = IO_LW;
          io_addr = pc_q;
        end
        S_MEM: begin
          io_req   = req_s;
          io_mode  = dec_io_mode;
          io_addr  = addr_q;
          io_wdata = dec_rd_data;
        end
        default: io_req = 1'b0;
      endcase
    end
  end

  // Next-state, register write-back and exception capture
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    dpc_d      = dpc_q;
    ds_d       = ds_q;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    addr_d     = addr_q;
    exc_code_d = exc_code_q;
    exc_epc_d  = exc_epc_q;
    exc_bd_d   = exc_bd_q;
    exc_bad_d  = exc_bad_q;
    reg_rd     = 5'd0;
    reg_wdata  = 32'd0;
    case (state_q)
      S_IF: begin
        if (pc_q[1:0] != 2'b00) begin
          exc_code_d = EXC_ADEL; exc_bad_d = pc_q;
          exc_epc_d = epc_s; exc_bd_d = ds_q; state_d = S_EXC;
        end else if (timeout_s) begin
          exc_code_d = EXC_BUS; exc_bad_d = 32'd0;
          exc_epc_d = epc_s; exc_bd_d = ds_q; state_d = S_EXC;
        end else if (io_ready) begin
          inst_d    = io_rdata;
          inst_pc_d = pc_q;
          pc_d      = ds_q ? dpc_q : (pc_q + 32'd4);
          state_d   = S_ID;
        end else begin
          state_d = S_IF;
        end
      end
      S_ID: begin
        if (dec_is_jump && ds_q) begin
          exc_code_d = EXC_RI; exc_bad_d = 32'd0;
          exc_epc_d = epc_s; exc_bd_d = ds_q; state_d = S_EXC;
        end else if (dec_is_jump || dec_rd_ready) begin
          // A jump opens a delay slot; a non-jump early write-back retires here
          ds_d  = dec_is_jump;
          dpc_d = dec_is_jump ? dec_jump_pc : dpc_q;
          if (dec_rd_ready) begin
            reg_rd    = dec_rd_idx;
            reg_wdata = dec_rd_data;
          end else begin
            reg_rd = 5'd0;
          end
          state_d = S_IF;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        if (dec_io_mode == IO_NOP) begin
          reg_rd    = dec_rd_idx;
          reg_wdata = alu_out;
          ds_d      = 1'b0;
          state_d   = S_IF;
        end else begin
          addr_d  = alu_out;
          state_d = S_MEM;
        end
      end
      S_MEM: begin
        if (mis_s) begin
          exc_code_d = (dec_io_mode == IO_LW) ? EXC_ADEL : EXC_ADES;
          exc_bad_d = addr_q; exc_epc_d = epc_s; exc_bd_d = ds_q; state_d = S_EXC;
        end else if (timeout_s) begin
          exc_code_d = EXC_BUS; exc_bad_d = 32'd0;
          exc_epc_d = epc_s; exc_bd_d = ds_q; state_d = S_EXC;
        end else if (io_ready) begin
          reg_rd    = dec_rd_idx;
          reg_wdata = io_rdata;
          ds_d      = 1'b0;
          state_d   = S_IF;
        end else begin
          state_d = S_MEM;
        end
      end
      S_EXC: begin
        pc_d    = EXC_VECTOR;
        ds_d    = 1'b0;
        state_d = S_IF;
      end
      default: state_d = S_IF;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IF;
      pc_q       <= RESET_PC;
      dpc_q      <= 32'd0;
      ds_q       <= 1'b0;
      inst_q     <= 32'd0;
      inst_pc_q  <= 32'd0;
      addr_q     <= 32'd0;
      wait_q     <= '0;
      exc_code_q <= 5'd0;
      exc_epc_q  <= 32'd0;
      exc_bd_q   <= 1'b0;
      exc_bad_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      dpc_q      <= dpc_d;
      ds_q       <= ds_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      addr_q     <= addr_d;
      wait_q     <= wait_d;
      exc_code_q <= exc_code_d;
      exc_epc_q  <= exc_epc_d;
      exc_bd_q   <= exc_bd_d;
      exc_bad_q  <= exc_bad_d;
    end
  end

endmodule

// File: tb/tb_cpu_ctrl_hs.sv
// Randomized bench for cpu_ctrl_hs: the bench plays memory and decoder and
// predicts every cycle from an instruction-level model of the sequencer.
module tb_cpu_ctrl_hs;

  localparam logic [31:0] RST_PC  = 32'h8000_0000;
  localparam logic [31:0] EXC_VEC = 32'h8000_1180;
  localparam int          TMO     = 8;
  localparam logic [3:0]  IO_NOP = 4'h0, IO_LW = 4'h1, IO_SW = 4'h2, IO_LB = 4'h3, IO_SB = 4'h4;
  localparam int K_ALU = 0, K_JMP = 1, K_JAL = 2, K_LUI = 3, K_LW = 4, K_SW = 5,
                 K_LB = 6, K_SB = 7, K_LWM = 8, K_SWM = 9, K_TMO = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        io_req, io_ready;
  logic [3:0]  io_mode;
  logic [31:0] io_addr, io_wdata, io_rdata;
  logic [31:0] inst, inst_pc, next_pc;
  logic        dec_rd_ready, dec_is_jump;
  logic [4:0]  dec_rd_idx;
  logic [31:0] dec_rd_data, dec_jump_pc, alu_out;
  logic [3:0]  dec_io_mode;
  logic [4:0]  reg_rd;
  logic [31:0] reg_wdata;
  logic        exc_valid, exc_bd;
  logic [4:0]  exc_code;
  logic [31:0] exc_epc, exc_badvaddr;

  cpu_ctrl_hs #(.BUS_TIMEOUT(TMO), .TO_W(8)) dut (
    .clk(clk), .rst(rst),
    .io_req(io_req), .io_mode(io_mode), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_ready(io_ready), .io_rdata(io_rdata),
    .inst(inst), .inst_pc(inst_pc), .next_pc(next_pc),
    .dec_rd_ready(dec_rd_ready), .dec_rd_idx(dec_rd_idx), .dec_rd_data(dec_rd_data),
    .dec_is_jump(dec_is_jump), .dec_jump_pc(dec_jump_pc), .dec_io_mode(dec_io_mode),
    .alu_out(alu_out), .reg_rd(reg_rd), .reg_wdata(reg_wdata),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_epc(exc_epc),
    .exc_bd(exc_bd), .exc_badvaddr(exc_badvaddr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Architectural model: fetch pc, delay-slot flag/target, current instruction
  logic [31:0] m_pc, m_dpc, m_ipc, m_inst;
  bit          m_ds;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] m_epc(input logic [31:0] pc, input bit ds);
    return ds ? pc - 32'd4 : pc;
  endfunction

  task automatic end_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_dec();
    dec_rd_ready = 1'($urandom);
    dec_rd_idx   = 5'($urandom);
    dec_rd_data  = $urandom;
    dec_is_jump  = 1'($urandom);
    dec_jump_pc  = $urandom;
    dec_io_mode  = 4'($urandom_range(0, 4));
    alu_out      = $urandom;
  endtask

  task automatic chk_bus(input string tag, input bit req, input logic [3:0] mode,
                         input logic [31:0] addr, input logic [31:0] wd, input bit chk_w);
    check_eq({tag, ".req"}, io_req, req);
    check_eq({tag, ".excv"}, exc_valid, 1'b0);
    if (req) begin
      check_eq({tag, ".mode"}, io_mode, mode);
      check_eq({tag, ".addr"}, io_addr, addr);
      if (chk_w) check_eq({tag, ".wdata"}, io_wdata, wd);
    end
  endtask

  task automatic chk_wr(input string tag, input bit wr, input logic [4:0] idx, input logic [31:0] d);
    if (wr) begin
      check_eq({tag, ".rd"}, reg_rd, idx);
      check_eq({tag, ".wdata"}, reg_wdata, d);
    end else begin
      check_eq({tag, ".rd"}, reg_rd, 5'd0);
    end
  endtask

  task automatic chk_exc(input string tag, input logic [4:0] code, input logic [31:0] epc,
                         input bit bd, input logic [31:0] bad);
    io_ready = 1'($urandom);
    rand_dec();
    #2;
    check_eq({tag, ".excv"}, exc_valid, 1'b1);
    check_eq({tag, ".code"}, exc_code, code);
    check_eq({tag, ".epc"}, exc_epc, epc);
    check_eq({tag, ".bd"}, exc_bd, bd);
    check_eq({tag, ".bad"}, exc_badvaddr, bad);
    check_eq({tag, ".rd"}, reg_rd, 5'd0);
    check_eq({tag, ".req"}, io_req, 1'b0);
    end_cycle();
    m_pc = EXC_VEC;
    m_ds = 1'b0;
  endtask

  task automatic do_fetch(input bit tmo, output bit ok);
    int w;
    logic [31:0] rd;
    ok = 1'b0;
    if (m_pc[1:0] != 2'b00) begin
      io_ready = 1'($urandom);
      rand_dec();
      #2;
      check_eq("if_adel.req", io_req, 1'b0);
      chk_wr("if_adel", 1'b0, 5'd0, 32'd0);
      end_cycle();
      chk_exc("if_adel", 5'd4, m_epc(m_pc, m_ds), m_ds, m_pc);
    end else if (tmo) begin
      for (int c = 0; c < TMO; c++) begin
        io_ready = 1'b0;
        rand_dec();
        #2;
        chk_bus("if_tmo", 1'b1, IO_LW, m_pc, 32'd0, 1'b0);
        chk_wr("if_tmo", 1'b0, 5'd0, 32'd0);
        end_cycle();
      end
      chk_exc("if_tmo", 5'd7, m_epc(m_pc, m_ds), m_ds, 32'd0);
    end else begin
      w = $urandom_range(0, 3);
      rd = 32'd0;
      for (int c = 0; c <= w; c++) begin
        io_ready = (c == w);
        rd = $urandom;
        io_rdata = rd;
        rand_dec();
        #2;
        chk_bus("if", 1'b1, IO_LW, m_pc, 32'd0, 1'b0);
        chk_wr("if", 1'b0, 5'd0, 32'd0);
        end_cycle();
      end
      m_inst = rd;
      m_ipc  = m_pc;
      m_pc   = m_ds ? m_dpc : m_pc + 32'd4;
      ok     = 1'b1;
    end
  endtask

  // One instruction after its fetch: v is the ALU result, memory address or jump target
  task automatic do_exec(input int kind, input logic [31:0] v, input logic [4:0] idx, input int wt);
    logic [31:0] data, rdat;
    logic [3:0]  mode;
    bit          jmp, rdy;
    int          w;
    data = $urandom;
    jmp  = (kind == K_JMP) || (kind == K_JAL);
    rdy  = (kind == K_JAL) || (kind == K_LUI);
    case (kind)
      K_LW, K_LWM:        mode = IO_LW;
      K_SW, K_SWM, K_TMO: mode = IO_SW;
      K_LB:               mode = IO_LB;
      K_SB:               mode = IO_SB;
      default:            mode = IO_NOP;
    endcase
    dec_rd_ready = rdy; dec_rd_idx = idx; dec_rd_data = data;
    dec_is_jump = jmp; dec_jump_pc = v; dec_io_mode = mode;
    alu_out = $urandom; io_ready = 1'($urandom); io_rdata = $urandom;
    #2;
    check_eq("id.inst", inst, m_inst);
    check_eq("id.inst_pc", inst_pc, m_ipc);
    check_eq("id.next_pc", next_pc, m_ipc + 32'd4);
    chk_bus("id", 1'b0, IO_NOP, 32'd0, 32'd0, 1'b0);
    if (jmp && m_ds) begin
      chk_wr("id_ri", 1'b0, 5'd0, 32'd0);
      end_cycle();
      chk_exc("ri", 5'd10, m_ipc - 32'd4, 1'b1, 32'd0);
      return;
    end
    if (jmp || rdy) begin
      chk_wr("id_wb", rdy, idx, data);
      end_cycle();
      m_ds  = jmp;
      m_dpc = jmp ? v : m_dpc;
      return;
    end
    chk_wr("id", 1'b0, 5'd0, 32'd0);
    end_cycle();
    alu_out = v; io_ready = 1'($urandom);
    #2;
    chk_bus("ex", 1'b0, IO_NOP, 32'd0, 32'd0, 1'b0);
    if (mode == IO_NOP) begin
      chk_wr("ex_alu", 1'b1, idx, v);
      end_cycle();
      m_ds = 1'b0;
      return;
    end
    chk_wr("ex", 1'b0, 5'd0, 32'd0);
    end_cycle();
    if (kind == K_LWM || kind == K_SWM) begin
      alu_out = $urandom; io_ready = 1'($urandom);
      #2;
      check_eq("mem_mis.req", io_req, 1'b0);
      chk_wr("mem_mis", 1'b0, 5'd0, 32'd0);
      end_cycle();
      chk_exc("mem_mis", (kind == K_LWM) ? 5'd4 : 5'd5, m_epc(m_ipc, m_ds), m_ds, v);
      return;
    end
    if (kind == K_TMO) begin
      for (int c = 0; c < TMO; c++) begin
        io_ready = 1'b0; alu_out = $urandom;
        #2;
        chk_bus("mem_tmo", 1'b1, mode, v, data, 1'b1);
        chk_wr("mem_tmo", 1'b0, 5'd0, 32'd0);
        end_cycle();
      end
      chk_exc("mem_tmo", 5'd7, m_epc(m_ipc, m_ds), m_ds, 32'd0);
      return;
    end
    w = (wt < 0) ? $urandom_range(0, 3) : wt;
    for (int c = 0; c <= w; c++) begin
      io_ready = (c == w);
      rdat = $urandom;
      io_rdata = rdat; alu_out = $urandom;
      #2;
      chk_bus("mem", 1'b1, mode, v, data, 1'b1);
      chk_wr("mem", c == w, idx, rdat);
      end_cycle();
    end
    m_ds = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    check_eq({tag, ".req"}, io_req, 1'b0);
    check_eq({tag, ".mode"}, io_mode, IO_NOP);
    check_eq({tag, ".addr"}, io_addr, 32'd0);
    check_eq({tag, ".wdata"}, io_wdata, 32'd0);
    check_eq({tag, ".inst"}, inst, 32'd0);
    check_eq({tag, ".inst_pc"}, inst_pc, 32'd0);
    check_eq({tag, ".next_pc"}, next_pc, 32'd4);
    check_eq({tag, ".rd"}, reg_rd, 5'd0);
    check_eq({tag, ".excv"}, exc_valid, 1'b0);
    check_eq({tag, ".code"}, exc_code, 5'd0);
    check_eq({tag, ".epc"}, exc_epc, 32'd0);
    check_eq({tag, ".bad"}, exc_badvaddr, 32'd0);
  endtask

  initial begin
    bit          ok;
    int          r, kind;
    logic [31:0] r32, v;
    rst = 1'b1; io_ready = 1'b1; io_rdata = 32'd0;
    rand_dec();
    m_pc = RST_PC; m_ds = 1'b0; m_dpc = 32'd0; m_ipc = 32'd0; m_inst = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 1'b0;

    // Directed: ALU, waited load, jump + jump in delay slot, misaligned load, store timeout
    do_fetch(1'b0, ok); do_exec(K_ALU, 32'h15, 5'd3, -1);
    do_fetch(1'b0, ok); do_exec(K_LW, 32'h8000_0400, 5'd5, 2);
    do_fetch(1'b0, ok); do_exec(K_JMP, 32'h8000_0100, 5'd0, -1);
    do_fetch(1'b0, ok); do_exec(K_JMP, 32'h8000_0200, 5'd0, -1);
    do_fetch(1'b0, ok); do_exec(K_LWM, 32'h8000_0402, 5'd7, -1);
    do_fetch(1'b0, ok); do_exec(K_TMO, 32'h8000_0800, 5'd0, -1);

    for (int i = 0; i < 400; i++) begin
      do_fetch($urandom_range(0, 39) == 0, ok);
      if (ok) begin
        r = $urandom_range(0, 99);
        kind = (r < 25) ? K_ALU : (r < 35) ? K_JMP : (r < 42) ? K_JAL : (r < 47) ? K_LUI :
               (r < 60) ? K_LW : (r < 70) ? K_SW : (r < 77) ? K_LB : (r < 82) ? K_SB :
               (r < 86) ? K_LWM : (r < 90) ? K_SWM : (r < 93) ? K_TMO : K_ALU;
        r32 = $urandom;
        case (kind)
          K_JMP, K_JAL: v = {16'h8000, r32[15:2], ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00};
          K_LW, K_SW, K_TMO: v = {r32[31:2], 2'b00};
          K_LWM, K_SWM: v = {r32[31:2], 2'($urandom_range(1, 3))};
          default: v = r32;
        endcase
        do_exec(kind, v, 5'($urandom), -1);
      end
    end

    // Reset asserted in the middle of a fetch drops io_req at once
    io_ready = 1'b0;
    #2;
    check_eq("mid_rst.pre_req", io_req, (m_pc[1:0] == 2'b00));
    #1 rst = 1'b1;
    #1;
    check_eq("mid_rst.req", io_req, 1'b0);
    chk_reset("mid_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    m_pc = RST_PC; m_ds = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_fetch(1'b0, ok);
      do_exec(K_ALU, $urandom, 5'($urandom), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
